// File: rtl/whack_io_responder.sv
// Memory-mapped I/O responder for the Whack-A-Mole game peripherals.
// It answers processor loads and stores in an 8-word window on the dmem bus.
// The window holds button capture, mole mask, score, countdown timer and LFSR.
module whack_io_responder #(
    parameter logic [11:0] IO_BASE   = 12'hF00,
    parameter int unsigned NUM_BTN   = 9,
    parameter int unsigned TICK_DIV  = 50000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [11:0]        address_dmem,
    input  logic [31:0]        d_dmem,
    input  logic               wren,
    input  logic [NUM_BTN-1:0] buttons,
    output logic [31:0]        io_q,
    output logic               io_hit,
    output logic [NUM_BTN-1:0] moles,
    output logic [15:0]        score,
    output logic               timer_expired
);

    localparam int unsigned PRE_W   = 20;
    localparam int unsigned TIMER_W = 20;

    localparam logic [2:0]  REG_EVT    = 3'd0;
    localparam logic [2:0]  REG_LVL    = 3'd1;
    localparam logic [2:0]  REG_MOLES  = 3'd2;
    localparam logic [2:0]  REG_SCORE  = 3'd3;
    localparam logic [2:0]  REG_TIMER  = 3'd4;
    localparam logic [2:0]  REG_STATUS = 3'd5;
    localparam logic [2:0]  REG_RAND   = 3'd6;

    localparam logic [15:0] LFSR_MASK  = 16'hB400;

    // State registers
    logic [NUM_BTN-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_BTN-1:0] evt_q, evt_d;
    logic [NUM_BTN-1:0] moles_q, moles_d;
    logic [15:0]        score_q, score_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               expired_q, expired_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               hit_q, hit_d;

    // Decode and helper signals
    logic               in_win_c;
    logic [2:0]         idx_c;
    logic               rd_c;
    logic               wr_c;
    logic [NUM_BTN-1:0] edge_c;
    logic               tick_c;
    logic               load_timer_c;
    logic               expire_c;
    logic [31:0]        sel_c;
    logic               unused_d_c;

    // Store data bits above the widest register are never used.
    assign unused_d_c = ^d_dmem[31:TIMER_W];

    // Address decode, button edge detect and prescaler wrap.
    always_comb begin
        in_win_c     = (address_dmem[11:3] == IO_BASE[11:3]);
        idx_c        = address_dmem[2:0];
        rd_c         = in_win_c & ~wren;
        wr_c         = in_win_c & wren;
        edge_c       = sync2_q & ~prev_q;
        tick_c       = (pre_q == PRE_W'(TICK_DIV - 1));
        load_timer_c = wr_c && (idx_c == REG_TIMER);
        expire_c     = tick_c && !load_timer_c && (timer_q == TIMER_W'(1));
    end

    // Read-data selection from the current register values.
    always_comb begin
        sel_c = 32'h0;
        case (idx_c)
            REG_EVT:    sel_c = 32'(evt_q);
            REG_LVL:    sel_c = 32'(sync2_q);
            REG_MOLES:  sel_c = 32'(moles_q);
            REG_SCORE:  sel_c = 32'(score_q);
            REG_TIMER:  sel_c = 32'(timer_q);
            REG_STATUS: sel_c = {30'h0, (timer_q != '0), expired_q};
            REG_RAND:   sel_c = 32'(lfsr_q);
            default:    sel_c = 32'h0;
        endcase
    end

    // Next-state logic for every register in the block.
    always_comb begin
        evt_d     = evt_q | edge_c;
        moles_d   = moles_q;
        score_d   = score_q;
        timer_d   = timer_q;
        expired_d = expired_q;
        pre_d     = pre_q + PRE_W'(1);
        lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0);
        rdata_d   = 32'h0;
        hit_d     = rd_c;

        // A read of the event register clears it, but a fresh edge still lands.
        if (rd_c && (idx_c == REG_EVT)) begin
            evt_d = edge_c;
        end

        if (rd_c) begin
            rdata_d = sel_c;
        end

        if (wr_c && (idx_c == REG_MOLES)) begin
            moles_d = d_dmem[NUM_BTN-1:0];
        end

        if (wr_c && (idx_c == REG_SCORE)) begin
            score_d = d_dmem[15:0];
        end

        // A load beats a coincident tick; otherwise count down to zero and stop.
        if (load_timer_c) begin
            timer_d = d_dmem[TIMER_W-1:0];
        end else if (tick_c && (timer_q != '0)) begin
            timer_d = timer_q - TIMER_W'(1);
        end

        // Expiry on the same edge as a W1C clear keeps the flag set.
        if (expire_c) begin
            expired_d = 1'b1;
        end else if (wr_c && (idx_c == REG_STATUS) && d_dmem[0]) begin
            expired_d = 1'b0;
        end

        if (tick_c) begin
            pre_d = '0;
        end
    end

    // Two-flop button synchronizer plus previous-level register for edge detect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= buttons;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Peripheral registers, prescaler, LFSR and registered read port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            evt_q     <= '0;
            moles_q   <= '0;
            score_q   <= '0;
            timer_q   <= '0;
            expired_q <= 1'b0;
            pre_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            rdata_q   <= 32'h0;
            hit_q     <= 1'b0;
        end else begin
            evt_q     <= evt_d;
            moles_q   <= moles_d;
            score_q   <= score_d;
            timer_q   <= timer_d;
            expired_q <= expired_d;
            pre_q     <= pre_d;
            lfsr_q    <= lfsr_d;
            rdata_q   <= rdata_d;
            hit_q     <= hit_d;
        end
    end

    assign io_q          = rdata_q;
    assign io_hit        = hit_q;
    assign moles         = moles_q;
    assign score         = score_q;
    assign timer_expired = expired_q;

endmodule

// File: doc/whack_io_responder.md
Name: whack_io_responder

Overview:
- Memory-mapped I/O responder on the processor's dmem-side bus (address/data/wren/q). Sits beside the dmem syncram.
- Answers processor loads/stores in a fixed 8-word I/O window. Top level muxes io_q over dmem q when io_hit is set.
- Holds game peripherals for Whack-A-Mole:
  - button event capture
  - mole display mask
  - score
  - countdown timer
  - free-running random source

Parameters:
- IO_BASE, 12'hF00, word address of register 0; the window is IO_BASE..IO_BASE+7.
- NUM_BTN, 9, number of button/mole lines.
- TICK_DIV, 50000, clock cycles per timer tick; legal range 2..2^20.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clock  in  1  sole clock; all state on its rising edge. The integrator drives it with the same phase as the dmem clock (~clock).
- reset  in  1  asynchronous, active-high.
- address_dmem  in  12  word address from processor.
- d_dmem  in  32  store data.
- wren  in  1  store enable.
- buttons  in  NUM_BTN  raw asynchronous button levels, active-high.
- io_q  out  32  registered read data.
- io_hit  out  1  registered; high when io_q carries I/O data.
- moles  out  NUM_BTN  mole display mask.
- score  out  16  score display value.
- timer_expired  out  1  sticky expired flag.

Behaviour:
- Reset is asynchronous and active-high. All outputs reset to 0. Internal state resets as follows:
  - all internal registers to 0
  - LFSR to LFSR_SEED
  - prescaler to 0
- Decode: in_win = (address_dmem[11:3] == IO_BASE[11:3]); idx = address_dmem[2:0].
- Read latency is one edge. On each edge:
  - io_hit <= in_win & ~wren.
  - io_q <= selected register if in_win & ~wren, else 32'h0.
  - Reads have no side effects except on BTN_EVT.
- Writes: when in_win & wren, the register at idx updates on that edge. Writes to read-only indices are ignored. io_hit <= 0 on a write.
- Register map (unused upper bits read 0):
  - 0 BTN_EVT (R)
    - Sticky rising-edge flags per button.
    - A read returns the flags and clears them on the same edge.
    - If a new edge arrives on the clearing edge, that bit stays set (set wins over clear).
  - 1 BTN_LVL (R): synchronized button levels.
  - 2 MOLES (R/W): low NUM_BTN bits; drives moles.
  - 3 SCORE (R/W): low 16 bits; drives score. No auto-increment.
  - 4 TIMER (R/W)
    - 20-bit tick counter; write loads d_dmem[19:0].
    - Decrements by 1 on each tick while nonzero; saturates at 0.
    - A transition from 1 to 0 sets expired.
  - 5 STATUS (R/W1C)
    - bit0 = expired, bit1 = (TIMER != 0).
    - Writing bit0=1 clears expired. If expiry happens on that same edge, expired stays set.
  - 6 RAND (R): current 16-bit LFSR value.
  - 7 reserved: reads 0, writes ignored.
- Buttons:
  - Two-flop synchronizer per line.
  - Edge = sync & ~sync_prev.
  - An event flag is visible in BTN_EVT 3 edges after a raw rising transition.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - The tick pulse is one cycle wide, at the wrap.
  - Runs continuously and is not reset by TIMER writes.
- TIMER load vs. tick on the same edge: the load wins and no decrement is applied. Loading 0 never sets expired.
- LFSR:
  - 16-bit Galois, mask 16'hB400.
  - Advances every cycle: next = (s>>1) ^ (s[0] ? 16'hB400 : 0).
  - Never reaches 0.
- timer_expired mirrors the STATUS bit0 register.
- Reset asserted mid-operation clears all state immediately. Pending events are lost, and io_hit drops without waiting for a clock.

Test Plan:
- Reset, then idle: moles=0, score=0, timer_expired=0, io_hit=0. Read idx 6 → io_q=0x0000ACE1 advanced by the cycles elapsed since reset, matching a reference LFSR model.
- Store 0x1FF to F02 and 0x1234 to F03 → moles=9'h1FF, score=16'h1234. Loads of F02/F03 return 0x1FF/0x1234 one edge later with io_hit=1. A load of 0x100 → io_hit=0, io_q=0.
- Pulse button 4 high for 10 cycles → BTN_EVT reads 0x010. A second read returns 0x000. Raise button 2 so its edge lands on the clearing read edge → next read returns 0x004.
- TICK_DIV=4, store 3 to F04 → TIMER reads 3,2,1,0 at 4-cycle spacing. timer_expired=1 on the edge TIMER hits 0, and TIMER stays 0. Store 1 to F05 → expired=0.
- Store 5 to F04 on the exact tick edge → TIMER=5, not 4. Store 0 to F04 → expired stays 0.
- Assert reset asynchronously mid-countdown with moles=0x0AA → moles, score, TIMER, BTN_EVT and expired read 0 immediately. The LFSR restarts from 0xACE1.
